// File: rtl/contra_vga_timing.sv
// contra_vga_timing
// 640x480@60 raster timing for the Contra display path. Produces the pixel
// coordinate handed to the background/sprite mappers, the display-enable and
// sync flags for that same pixel, delayed copies of the flags that line up
// with the mapper RGB output, and a frame pulse/counter for game logic.
// Everything is registered on vga_clk; there is no input-to-output path.
//
// Handshake: none. The block free-runs one pixel per vga_clk and every output
// is valid in every cycle outside reset; consumers sample whenever they need.

module contra_vga_timing #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2,
    parameter int FC_WIDTH   = 16
) (
    input  logic                vga_clk,
    input  logic                reset,
    output logic [9:0]          DrawX,
    output logic [9:0]          DrawY,
    output logic                blank,
    output logic                hs,
    output logic                vs,
    output logic                hs_d,
    output logic                vs_d,
    output logic                blank_d,
    output logic                frame_start,
    output logic [FC_WIDTH-1:0] frame_count
);

    // Raster geometry, all reduced to 10-bit unsigned compare values.
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Geometry that cannot be represented is rejected at elaboration.
    if (H_TOTAL > 1024 || H_TOTAL < 2) begin : g_bad_h_total
        $error("contra_vga_timing: horizontal total must be 2..1024");
    end
    if (V_TOTAL > 1024 || V_TOTAL < 2) begin : g_bad_v_total
        $error("contra_vga_timing: vertical total must be 2..1024");
    end
    if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
        $error("contra_vga_timing: sync widths must be at least 1");
    end
    if (PIPE_DELAY < 0) begin : g_bad_delay
        $error("contra_vga_timing: PIPE_DELAY must be non-negative");
    end
    if (FC_WIDTH < 1) begin : g_bad_fc
        $error("contra_vga_timing: FC_WIDTH must be at least 1");
    end

    // Raster position and per-pixel flags.
    logic [9:0]          x_q, x_d;
    logic [9:0]          y_q, y_d;
    logic                vis_q, vis_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                fs_q, fs_d;
    logic [FC_WIDTH-1:0] fc_q, fc_d;

    // Next pixel position; flags are derived from that next position so they
    // land in the same cycle as the coordinate they describe.
    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
                y_d = '0;
            end else begin
                y_d = y_q + 10'd1;
            end
        end

        vis_d   = (x_d < H_VIS_END) && (y_d < V_VIS_END);
        hsync_d = !((x_d >= H_SYNC_FIRST) && (x_d <= H_SYNC_LAST));
        vsync_d = !((y_d >= V_SYNC_FIRST) && (y_d <= V_SYNC_LAST));
        fs_d    = (x_d == 10'd0) && (y_d == 10'd0);

        fc_d = fc_q;
        if (fs_d) begin
            fc_d = fc_q + FC_WIDTH'(1);
        end
    end

    // Reset parks the raster on the last pixel so the first live edge is (0,0).
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            x_q     <= H_LAST;
            y_q     <= V_LAST;
            vis_q   <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            fs_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            vis_q   <= vis_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign blank       = vis_q;
    assign hs          = hsync_q;
    assign vs          = vsync_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;

    // Delayed sync/enable copies matching the mapper RGB latency.
    if (PIPE_DELAY == 0) begin : g_no_delay
        assign hs_d    = hsync_q;
        assign vs_d    = vsync_q;
        assign blank_d = vis_q;
    end else begin : g_delay
        logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
        logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
        logic [PIPE_DELAY-1:0] vis_pipe_q, vis_pipe_d;

        // Shift each flag one stage further down its delay line.
        always_comb begin
            hs_pipe_d[0]  = hsync_q;
            vs_pipe_d[0]  = vsync_q;
            vis_pipe_d[0] = vis_q;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_pipe_d[i]  = hs_pipe_q[i-1];
                vs_pipe_d[i]  = vs_pipe_q[i-1];
                vis_pipe_d[i] = vis_pipe_q[i-1];
            end
        end

        // Syncs idle high and display disabled in every stage during reset.
        always_ff @(posedge vga_clk) begin
            if (reset) begin
                hs_pipe_q  <= '1;
                vs_pipe_q  <= '1;
                vis_pipe_q <= '0;
            end else begin
                hs_pipe_q  <= hs_pipe_d;
                vs_pipe_q  <= vs_pipe_d;
                vis_pipe_q <= vis_pipe_d;
            end
        end

        assign hs_d    = hs_pipe_q[PIPE_DELAY-1];
        assign vs_d    = vs_pipe_q[PIPE_DELAY-1];
        assign blank_d = vis_pipe_q[PIPE_DELAY-1];
    end

endmodule

// File: tb/tb_contra_vga_timing.sv
// Bench for contra_vga_timing: a full-size 640x480 instance (a) for reset,
// line timing, delay line and mid-frame reset, and a shrunken 15x10 raster
// instance (b, FC_WIDTH=2) so frame-level behaviour fits in a short run.
// Instance b geometry: H 8/2/3/2 (total 15, hs low X=10..12),
// V 6/1/2/1 (total 10, vs low Y=7..8), frame = 150 cycles.

module tb_contra_vga_timing;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic [9:0]  a_x, a_y, b_x, b_y;
    logic        a_blank, a_hs, a_vs, a_hs_d, a_vs_d, a_blank_d, a_fs;
    logic        b_blank, b_hs, b_vs, b_hs_d, b_vs_d, b_blank_d, b_fs;
    logic [15:0] a_fc;
    logic [1:0]  b_fc;

    int errors = 0;
    int checks = 0;

    // Reference raster models: position plus two-deep flag history {hs,vs,blank}.
    int ax = 799, ay = 524, bx = 14, by = 9;
    logic [2:0] ah1 = 3'b110, ah2 = 3'b110, bh1 = 3'b110, bh2 = 3'b110;

    contra_vga_timing u_dut_a (
        .vga_clk(clk), .reset(rst_a), .DrawX(a_x), .DrawY(a_y), .blank(a_blank),
        .hs(a_hs), .vs(a_vs), .hs_d(a_hs_d), .vs_d(a_vs_d), .blank_d(a_blank_d),
        .frame_start(a_fs), .frame_count(a_fc)
    );

    contra_vga_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIPE_DELAY(2), .FC_WIDTH(2)
    ) u_dut_b (
        .vga_clk(clk), .reset(rst_b), .DrawX(b_x), .DrawY(b_y), .blank(b_blank),
        .hs(b_hs), .vs(b_vs), .hs_d(b_hs_d), .vs_d(b_vs_d), .blank_d(b_blank_d),
        .frame_start(b_fs), .frame_count(b_fc)
    );

    function automatic logic m_vis(input int x, input int y, input int hv, input int vv);
        return (x < hv) && (y < vv);
    endfunction

    function automatic logic m_sync(input int p, input int lo, input int hi);
        return !((p >= lo) && (p <= hi));
    endfunction

    // Advance n clocks; outputs are sampled 1 time unit after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            logic ra, rb;
            ra = rst_a;
            rb = rst_b;
            @(posedge clk);
            #1;
            if (ra) begin
                ax = 799; ay = 524; ah1 = 3'b110; ah2 = 3'b110;
            end else begin
                ah2 = ah1;
                ah1 = {m_sync(ax, 656, 751), m_sync(ay, 490, 491), m_vis(ax, ay, 640, 480)};
                if (ax == 799) begin ax = 0; ay = (ay == 524) ? 0 : ay + 1; end
                else ax = ax + 1;
            end
            if (rb) begin
                bx = 14; by = 9; bh1 = 3'b110; bh2 = 3'b110;
            end else begin
                bh2 = bh1;
                bh1 = {m_sync(bx, 10, 12), m_sync(by, 7, 8), m_vis(bx, by, 8, 6)};
                if (bx == 14) begin bx = 0; by = (by == 9) ? 0 : by + 1; end
                else bx = bx + 1;
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        step(3);
        checks++; if (a_x !== 10'd799) begin errors++; $display("FAIL rst_drawx: got %0d expected 799", a_x); end
        checks++; if (a_y !== 10'd524) begin errors++; $display("FAIL rst_drawy: got %0d expected 524", a_y); end
        checks++; if (a_blank !== 1'b0) begin errors++; $display("FAIL rst_blank: got %b expected 0", a_blank); end
        checks++; if (a_hs !== 1'b1) begin errors++; $display("FAIL rst_hs: got %b expected 1", a_hs); end
        checks++; if (a_vs !== 1'b1) begin errors++; $display("FAIL rst_vs: got %b expected 1", a_vs); end
        checks++; if (a_fs !== 1'b0) begin errors++; $display("FAIL rst_fs: got %b expected 0", a_fs); end
        checks++; if (a_fc !== 16'd0) begin errors++; $display("FAIL rst_fc: got %0d expected 0", a_fc); end
        checks++; if ({a_hs_d, a_vs_d, a_blank_d} !== 3'b110) begin errors++; $display("FAIL rst_delayed: got %b expected 110", {a_hs_d, a_vs_d, a_blank_d}); end
        checks++; if ({b_x, b_y} !== {10'd14, 10'd9}) begin errors++; $display("FAIL rst_b_xy: got %0d,%0d expected 14,9", b_x, b_y); end
        rst_a = 1'b0;
        rst_b = 1'b0;
        step(1);
        checks++; if ({a_x, a_y} !== 20'd0) begin errors++; $display("FAIL rel_xy: got %0d,%0d expected 0,0", a_x, a_y); end
        checks++; if (a_blank !== 1'b1) begin errors++; $display("FAIL rel_blank: got %b expected 1", a_blank); end
        checks++; if (a_fs !== 1'b1) begin errors++; $display("FAIL rel_fs: got %b expected 1", a_fs); end
        checks++; if (a_fc !== 16'd1) begin errors++; $display("FAIL rel_fc: got %0d expected 1", a_fc); end
        checks++; if ({a_hs, a_vs} !== 2'b11) begin errors++; $display("FAIL rel_sync: got %b expected 11", {a_hs, a_vs}); end
        checks++; if (a_blank_d !== 1'b0) begin errors++; $display("FAIL rel_blank_d: got %b expected 0", a_blank_d); end
    endtask

    // Starts at (0,0): walks line 0 and the wrap into line 1.
    task automatic test_line();
        int bad_x = 0, bad_blank = 0, bad_hs = 0, hs_low = 0;
        int blank_fall = -1, hs_first = -1;
        for (int i = 0; i < 800; i++) begin
            if (a_x !== 10'(i) || a_y !== 10'd0) bad_x++;
            if (a_blank !== (i < 640)) bad_blank++;
            if (a_hs !== m_sync(i, 656, 751)) bad_hs++;
            if (a_hs === 1'b0) begin hs_low++; if (hs_first < 0) hs_first = i; end
            if (a_blank === 1'b0 && blank_fall < 0) blank_fall = i;
            step(1);
        end
        checks++; if (bad_x != 0) begin errors++; $display("FAIL line_coords: got %0d bad cycles expected 0", bad_x); end
        checks++; if (bad_blank != 0) begin errors++; $display("FAIL line_blank: got %0d bad cycles expected 0", bad_blank); end
        checks++; if (bad_hs != 0) begin errors++; $display("FAIL line_hs: got %0d bad cycles expected 0", bad_hs); end
        checks++; if (hs_low != 96) begin errors++; $display("FAIL line_hs_width: got %0d expected 96", hs_low); end
        checks++; if (hs_first != 656) begin errors++; $display("FAIL line_hs_start: got %0d expected 656", hs_first); end
        checks++; if (blank_fall != 640) begin errors++; $display("FAIL line_blank_fall: got %0d expected 640", blank_fall); end
        checks++; if ({a_x, a_y} !== {10'd0, 10'd1}) begin errors++; $display("FAIL line_wrap: got %0d,%0d expected 0,1", a_x, a_y); end
        checks++; if (a_fs !== 1'b0 || a_fc !== 16'd1) begin errors++; $display("FAIL line_no_fs: got fs=%b fc=%0d expected fs=0 fc=1", a_fs, a_fc); end
    endtask

    // Starts at (0,1): delayed flags across line 1 and the wrap into line 2.
    task automatic test_delay_line();
        int bad = 0;
        logic [7:0] cap = 'x;
        for (int i = 0; i < 804; i++) begin
            if ({a_hs_d, a_vs_d, a_blank_d} !== ah2) bad++;
            if (ay == 1 && ax == 641) cap[0] = a_blank_d;
            if (ay == 1 && ax == 642) cap[1] = a_blank_d;
            if (ay == 1 && ax == 657) cap[2] = a_hs_d;
            if (ay == 1 && ax == 658) cap[3] = a_hs_d;
            if (ay == 1 && ax == 753) cap[4] = a_hs_d;
            if (ay == 1 && ax == 754) cap[5] = a_hs_d;
            if (ay == 2 && ax == 1)   cap[6] = a_blank_d;
            if (ay == 2 && ax == 2)   cap[7] = a_blank_d;
            step(1);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL delay_line_track: got %0d bad cycles expected 0", bad); end
        checks++; if (cap !== 8'b1010_0101) begin errors++; $display("FAIL delay_line_points: got %b expected 10100101", cap); end
    endtask

    task automatic test_mid_reset();
        step(300 - ax);
        checks++; if ({a_x, a_y} !== {10'd300, 10'd2}) begin errors++; $display("FAIL mid_pos: got %0d,%0d expected 300,2", a_x, a_y); end
        rst_a = 1'b1;
        step(1);
        checks++; if ({a_x, a_y} !== {10'd799, 10'd524}) begin errors++; $display("FAIL mid_rst_xy: got %0d,%0d expected 799,524", a_x, a_y); end
        checks++; if ({a_blank, a_hs, a_vs, a_fs} !== 4'b0110) begin errors++; $display("FAIL mid_rst_flags: got %b expected 0110", {a_blank, a_hs, a_vs, a_fs}); end
        checks++; if (a_fc !== 16'd0) begin errors++; $display("FAIL mid_rst_fc: got %0d expected 0", a_fc); end
        checks++; if ({a_hs_d, a_vs_d, a_blank_d} !== 3'b110) begin errors++; $display("FAIL mid_rst_delayed: got %b expected 110", {a_hs_d, a_vs_d, a_blank_d}); end
        rst_a = 1'b0;
        step(1);
        checks++; if ({a_x, a_y} !== 20'd0) begin errors++; $display("FAIL mid_rel_xy: got %0d,%0d expected 0,0", a_x, a_y); end
        checks++; if (a_fs !== 1'b1 || a_fc !== 16'd1) begin errors++; $display("FAIL mid_rel_fc: got fs=%b fc=%0d expected fs=1 fc=1", a_fs, a_fc); end
    endtask

    // Small raster: vsync width, frame period, frame counter step.
    task automatic test_frame();
        int vs_low = 0, bad_vs = 0, extra_fs = 0, n = 0;
        rst_b = 1'b1;
        step(1);
        rst_b = 1'b0;
        step(1);
        for (int i = 0; i < 150; i++) begin
            if (b_vs === 1'b0) vs_low++;
            if (b_vs !== m_sync(by, 7, 8)) bad_vs++;
            if (i > 0 && b_fs !== 1'b0) extra_fs++;
            step(1);
        end
        checks++; if (vs_low != 30) begin errors++; $display("FAIL frame_vs_width: got %0d expected 30", vs_low); end
        checks++; if (bad_vs != 0) begin errors++; $display("FAIL frame_vs_lines: got %0d bad cycles expected 0", bad_vs); end
        checks++; if (extra_fs != 0) begin errors++; $display("FAIL frame_extra_fs: got %0d expected 0", extra_fs); end
        checks++; if ({b_x, b_y, b_fs} !== 21'd1) begin errors++; $display("FAIL frame_wrap: got %0d,%0d fs=%b expected 0,0 fs=1", b_x, b_y, b_fs); end
        checks++; if (b_fc !== 2'd2) begin errors++; $display("FAIL frame_fc: got %0d expected 2", b_fc); end
        do begin step(1); n++; end while (b_fs !== 1'b1 && n < 400);
        checks++; if (n != 150) begin errors++; $display("FAIL frame_period: got %0d expected 150", n); end
    endtask

    // Starts at (0,0) of small raster: delayed flags across a frame wrap.
    task automatic test_delay_frame();
        int bad = 0;
        logic [4:0] cap = 'x;
        for (int i = 0; i < 160; i++) begin
            if ({b_hs_d, b_vs_d, b_blank_d} !== bh2) bad++;
            if (by == 9 && bx == 1) cap[0] = b_vs_d;
            if (by == 9 && bx == 2) cap[1] = b_vs_d;
            if (by == 0 && bx == 0 && i > 0) cap[2] = b_vs_d;
            if (by == 0 && bx == 1 && i > 0) cap[3] = b_blank_d;
            if (by == 0 && bx == 2 && i > 0) cap[4] = b_blank_d;
            step(1);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL delay_frame_track: got %0d bad cycles expected 0", bad); end
        checks++; if (cap !== 5'b10110) begin errors++; $display("FAIL delay_frame_points: got %b expected 10110", cap); end
    endtask

    // FC_WIDTH=2 wraps 3 -> 0.
    task automatic test_fc_wrap();
        logic [1:0] exp_fc [3] = '{2'd2, 2'd3, 2'd0};
        rst_b = 1'b1;
        step(1);
        rst_b = 1'b0;
        step(1);
        checks++; if (b_fc !== 2'd1) begin errors++; $display("FAIL fc_first: got %0d expected 1", b_fc); end
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            do begin step(1); n++; end while (b_fs !== 1'b1 && n < 400);
            checks++; if (b_fs !== 1'b1 || b_fc !== exp_fc[k]) begin errors++; $display("FAIL fc_seq%0d: got %0d (fs=%b) expected %0d", k, b_fc, b_fs, exp_fc[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_delay_line();
        test_mid_reset();
        test_frame();
        test_delay_frame();
        test_fc_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
